// File: rtl/mac_pkg.sv
// Shared definitions for the MAC array: accumulate-mode encoding, the beat tag
// that travels alongside the datapath, and the saturating clamp helper.
package mac_pkg;

    typedef enum logic {
        ACC_EXTERNAL = 1'b0,
        ACC_INTERNAL = 1'b1
    } acc_mode_e;

    typedef struct packed {
        logic      nop;
        acc_mode_e acc_mode;
        logic      first;
        logic      last;
    } tag_t;

    localparam tag_t TagBubble = '{nop: 1'b1, acc_mode: ACC_EXTERNAL, first: 1'b0, last: 1'b0};

    // Widest accumulator the clamp helper can serve; sums are carried one bit wider.
    localparam int MaxAccWidth = 64;

    function automatic logic signed [MaxAccWidth:0] sat_max(input int width);
        logic signed [MaxAccWidth:0] one;
        one    = '0;
        one[0] = 1'b1;
        return (one <<< (width - 1)) - one;
    endfunction

    function automatic logic signed [MaxAccWidth:0] sat_min(input int width);
        logic signed [MaxAccWidth:0] one;
        one    = '0;
        one[0] = 1'b1;
        return -(one <<< (width - 1));
    endfunction

    function automatic logic signed [MaxAccWidth:0] sat_clamp(
        input logic signed [MaxAccWidth:0] sum,
        input int                          width
    );
        logic signed [MaxAccWidth:0] hi;
        logic signed [MaxAccWidth:0] lo;
        logic signed [MaxAccWidth:0] res;
        hi = sat_max(width);
        lo = sat_min(width);
        if (sum > hi) begin
            res = hi;
        end else if (sum < lo) begin
            res = lo;
        end else begin
            res = sum;
        end
        return res;
    endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC channel: pipelined signed multiply, delayed external partial sum,
// and the output stage that either adds O_Data or updates the running accumulator.
module mac_lane
    import mac_pkg::*;
#(
    parameter int DataWidth           = 16,
    parameter int AccWidth            = 40,
    parameter int MUL_Pipeline_Stages = 2,
    parameter int ADD_Pipeline_Stages = 3,
    parameter bit Saturate            = 1'b0
) (
    input  logic                        clk,
    input  logic                        aclr,
    input  logic                        en,
    input  logic signed [DataWidth-1:0] w,
    input  logic signed [DataWidth-1:0] i,
    input  logic signed [AccWidth-1:0]  o,
    input  tag_t                        tag_out,
    output logic signed [AccWidth-1:0]  dout
);

    localparam int Latency     = MUL_Pipeline_Stages + ADD_Pipeline_Stages;
    localparam int DelayStages = Latency - 1;

    function automatic logic signed [AccWidth-1:0] add_acc(
        input logic signed [AccWidth-1:0] a,
        input logic signed [AccWidth-1:0] b
    );
        logic signed [AccWidth:0]    sum;
        logic signed [MaxAccWidth:0] wide;
        logic signed [AccWidth-1:0]  res;
        sum = (AccWidth+1)'(a) + (AccWidth+1)'(b);
        if (Saturate) begin
            wide = (MaxAccWidth+1)'(sum);
            wide = sat_clamp(wide, AccWidth);
            res  = wide[AccWidth-1:0];
        end else begin
            res = sum[AccWidth-1:0];
        end
        return res;
    endfunction

    logic signed [2*DataWidth-1:0] product;
    logic signed [AccWidth-1:0]    prod_p [DelayStages];
    logic signed [AccWidth-1:0]    o_p    [DelayStages];
    logic signed [AccWidth-1:0]    acc;
    logic signed [AccWidth-1:0]    acc_base;
    logic signed [AccWidth-1:0]    acc_next;
    logic signed [AccWidth-1:0]    sum_ext;

    assign product = (2*DataWidth)'(w) * (2*DataWidth)'(i);

    // Multiply/add delay stages: the first MUL stages hold the product, the rest carry it to the adder.
    always_ff @(posedge clk) begin
        if (en) begin
            prod_p[0] <= AccWidth'(product);
            o_p[0]    <= o;
            for (int s = 1; s < DelayStages; s++) begin
                prod_p[s] <= prod_p[s-1];
                o_p[s]    <= o_p[s-1];
            end
        end
    end

    always_comb begin
        acc_base = tag_out.first ? '0 : acc;
        acc_next = add_acc(acc_base, prod_p[DelayStages-1]);
        sum_ext  = add_acc(prod_p[DelayStages-1], o_p[DelayStages-1]);
    end

    // Output stage: bubbles leave both acc and dout untouched.
    always_ff @(posedge clk) begin
        if (aclr) begin
            acc  <= '0;
            dout <= '0;
        end else if (en && !tag_out.nop) begin
            if (tag_out.acc_mode == ACC_EXTERNAL) begin
                dout <= sum_ext;
            end else begin
                acc <= acc_next;
                if (tag_out.last) begin
                    dout <= acc_next;
                end
            end
        end
    end

endmodule

// File: rtl/mac_array_pipeline.sv
// Multi-lane pipelined MAC array: a shared tag pipeline steers Lanes independent
// mac_lane datapaths between external-partial-sum and internal-accumulate modes.
module mac_array_pipeline
    import mac_pkg::*;
#(
    parameter int DataWidth           = 16,
    parameter int AccWidth            = 40,
    parameter int Lanes               = 4,
    parameter int MUL_Pipeline_Stages = 2,
    parameter int ADD_Pipeline_Stages = 3,
    parameter bit Saturate            = 1'b0
) (
    input  logic                          clk,
    input  logic                          aclr,
    input  logic                          en,
    input  logic                          NOPIn,
    input  logic                          AccMode,
    input  logic                          First,
    input  logic                          Last,
    input  logic [Lanes*DataWidth-1:0]    W_Data,
    input  logic [Lanes*DataWidth-1:0]    I_Data,
    input  logic [Lanes*AccWidth-1:0]     O_Data,
    output logic                          NOPOut,
    output logic [Lanes*AccWidth-1:0]     DataOut
);

    localparam int Latency   = MUL_Pipeline_Stages + ADD_Pipeline_Stages;
    localparam int TagStages = Latency - 1;

    tag_t tag_in;
    tag_t tag_p [TagStages];
    tag_t tag_out;
    logic emit;

    always_comb begin
        tag_in  = '{nop: NOPIn, acc_mode: acc_mode_e'(AccMode), first: First, last: Last};
        tag_out = tag_p[TagStages-1];
        emit    = !tag_out.nop && ((tag_out.acc_mode == ACC_EXTERNAL) || tag_out.last);
    end

    // Tag stages: one entry per delay stage, aligned with the lane datapath.
    always_ff @(posedge clk) begin
        if (aclr) begin
            for (int s = 0; s < TagStages; s++) begin
                tag_p[s] <= TagBubble;
            end
            NOPOut <= 1'b1;
        end else if (en) begin
            tag_p[0] <= tag_in;
            for (int s = 1; s < TagStages; s++) begin
                tag_p[s] <= tag_p[s-1];
            end
            NOPOut <= !emit;
        end
    end

    for (genvar l = 0; l < Lanes; l++) begin : g_lane
        mac_lane #(
            .DataWidth           (DataWidth),
            .AccWidth            (AccWidth),
            .MUL_Pipeline_Stages (MUL_Pipeline_Stages),
            .ADD_Pipeline_Stages (ADD_Pipeline_Stages),
            .Saturate            (Saturate)
        ) u_lane (
            .clk     (clk),
            .aclr    (aclr),
            .en      (en),
            .w       (W_Data[l*DataWidth +: DataWidth]),
            .i       (I_Data[l*DataWidth +: DataWidth]),
            .o       (O_Data[l*AccWidth +: AccWidth]),
            .tag_out (tag_out),
            .dout    (DataOut[l*AccWidth +: AccWidth])
        );
    end

endmodule

// File: tb/tb_mac_array_pipeline.sv
// Bench for mac_array_pipeline: three instances (40-bit wrap, 32-bit saturate,
// 32-bit wrap) share one stimulus stream and are checked against a timestamped beat model.
module tb_mac_array_pipeline;

    localparam int DW  = 16;
    localparam int AW  = 40;
    localparam int AWN = 32;
    localparam int LN  = 4;
    localparam int L   = 5;
    localparam int ND  = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic aclr, en, nop_in, acc_mode, first, last;
    logic signed [DW-1:0] w_l [LN];
    logic signed [DW-1:0] i_l [LN];
    logic signed [AW-1:0] o_l [LN];
    logic [LN*DW-1:0]  w_data, i_data;
    logic [LN*AW-1:0]  o_data;
    logic [LN*AWN-1:0] o_data_n;
    logic              nop_a, nop_s, nop_w;
    logic [LN*AW-1:0]  dout_a;
    logic [LN*AWN-1:0] dout_s, dout_w;

    always_comb begin
        w_data   = '0;
        i_data   = '0;
        o_data   = '0;
        o_data_n = '0;
        for (int l = 0; l < LN; l++) begin
            w_data[l*DW +: DW]     = w_l[l];
            i_data[l*DW +: DW]     = i_l[l];
            o_data[l*AW +: AW]     = o_l[l];
            o_data_n[l*AWN +: AWN] = o_l[l][AWN-1:0];
        end
    end

    mac_array_pipeline #(.DataWidth(DW), .AccWidth(AW), .Lanes(LN),
        .MUL_Pipeline_Stages(2), .ADD_Pipeline_Stages(3), .Saturate(1'b0)) dut_a (
        .clk(clk), .aclr(aclr), .en(en), .NOPIn(nop_in), .AccMode(acc_mode),
        .First(first), .Last(last), .W_Data(w_data), .I_Data(i_data),
        .O_Data(o_data), .NOPOut(nop_a), .DataOut(dout_a));

    mac_array_pipeline #(.DataWidth(DW), .AccWidth(AWN), .Lanes(LN),
        .MUL_Pipeline_Stages(2), .ADD_Pipeline_Stages(3), .Saturate(1'b1)) dut_s (
        .clk(clk), .aclr(aclr), .en(en), .NOPIn(nop_in), .AccMode(acc_mode),
        .First(first), .Last(last), .W_Data(w_data), .I_Data(i_data),
        .O_Data(o_data_n), .NOPOut(nop_s), .DataOut(dout_s));

    mac_array_pipeline #(.DataWidth(DW), .AccWidth(AWN), .Lanes(LN),
        .MUL_Pipeline_Stages(2), .ADD_Pipeline_Stages(3), .Saturate(1'b0)) dut_w (
        .clk(clk), .aclr(aclr), .en(en), .NOPIn(nop_in), .AccMode(acc_mode),
        .First(first), .Last(last), .W_Data(w_data), .I_Data(i_data),
        .O_Data(o_data_n), .NOPOut(nop_w), .DataOut(dout_w));

    int n_checks = 0;
    int n_pass   = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        int                    stamp;
        logic                  mode;
        logic                  first;
        logic                  last;
        logic [LN-1:0][DW-1:0] w;
        logic [LN-1:0][DW-1:0] i;
        logic [LN-1:0][AW-1:0] o;
    } beat_t;

    beat_t  q[$];
    int     edge_cnt = 0;
    longint m_acc  [ND][LN];
    longint m_dout [ND][LN];
    bit     m_nop  [ND];

    function automatic int width_of(input int d);
        return (d == 0) ? AW : AWN;
    endfunction

    function automatic longint sext(input longint x, input int w);
        return (x <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic longint add_model(input longint a, input longint b, input int w, input bit sat);
        longint s, hi, lo;
        s  = a + b;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -(longint'(1) <<< (w - 1));
        if (sat) return (s > hi) ? hi : ((s < lo) ? lo : s);
        return sext(s, w);
    endfunction

    task automatic retire(input beat_t b);
        longint prod, ov;
        int     wd;
        for (int d = 0; d < ND; d++) begin
            wd = width_of(d);
            for (int l = 0; l < LN; l++) begin
                prod = longint'($signed(b.w[l])) * longint'($signed(b.i[l]));
                ov   = sext(longint'(b.o[l]), wd);
                if (!b.mode) begin
                    m_dout[d][l] = add_model(prod, ov, wd, d == 1);
                end else begin
                    m_acc[d][l] = add_model(b.first ? 64'sd0 : m_acc[d][l], prod, wd, d == 1);
                    if (b.last) m_dout[d][l] = m_acc[d][l];
                end
            end
            m_nop[d] = !(!b.mode || b.last);
        end
    endtask

    task automatic model_step();
        beat_t b;
        if (aclr) begin
            q.delete();
            for (int d = 0; d < ND; d++) begin
                m_nop[d] = 1'b1;
                for (int l = 0; l < LN; l++) begin
                    m_acc[d][l]  = 0;
                    m_dout[d][l] = 0;
                end
            end
        end else if (en) begin
            edge_cnt++;
            for (int d = 0; d < ND; d++) m_nop[d] = 1'b1;
            if (q.size() > 0 && q[0].stamp + L - 1 == edge_cnt) begin
                b = q.pop_front();
                retire(b);
            end
            if (!nop_in) begin
                b.stamp = edge_cnt;
                b.mode  = acc_mode;
                b.first = first;
                b.last  = last;
                for (int l = 0; l < LN; l++) begin
                    b.w[l] = w_l[l];
                    b.i[l] = i_l[l];
                    b.o[l] = o_l[l];
                end
                q.push_back(b);
            end
        end
    endtask

    function automatic logic signed [63:0] get_out(input int d, input int l);
        logic signed [63:0] r;
        case (d)
            0:       r = 64'($signed(dout_a[l*AW +: AW]));
            1:       r = 64'($signed(dout_s[l*AWN +: AWN]));
            default: r = 64'($signed(dout_w[l*AWN +: AWN]));
        endcase
        return r;
    endfunction

    function automatic logic get_nop(input int d);
        return (d == 0) ? nop_a : ((d == 1) ? nop_s : nop_w);
    endfunction

    always @(negedge clk) begin
        if (checking) begin
            for (int d = 0; d < ND; d++) begin
                chk($sformatf("nop_d%0d", d), 64'(get_nop(d)), 64'(m_nop[d]));
                for (int l = 0; l < LN; l++) begin
                    chk($sformatf("dout_d%0d_l%0d", d, l), get_out(d, l), m_dout[d][l]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_idle();
        nop_in = 1'b1; acc_mode = 1'b0; first = 1'b0; last = 1'b0;
        for (int l = 0; l < LN; l++) begin
            w_l[l] = '0; i_l[l] = '0; o_l[l] = '0;
        end
    endtask

    task automatic set_beat(input logic mode, input logic f, input logic la);
        nop_in = 1'b0; acc_mode = mode; first = f; last = la;
    endtask

    function automatic logic signed [DW-1:0] rand_op();
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 7))
            0:       return -16'sd32768;
            1:       return 16'sd32767;
            default: return r[DW-1:0];
        endcase
    endfunction

    initial begin
        logic [63:0] r64;
        aclr = 1'b1; en = 1'b0;
        set_idle();
        step();
        step();
        checking = 1'b1;
        chk("rst_nop", 64'(nop_a), 1);
        chk("rst_dout", 64'(dout_a[63:0]), 0);
        aclr = 1'b0; en = 1'b1;

        // mode 0, two back-to-back beats
        w_l[0] = 15; i_l[0] = 4; o_l[0] = 40; set_beat(1'b0, 1'b0, 1'b0);
        step();
        w_l[0] = 100; i_l[0] = 200; o_l[0] = 1000;
        step();
        set_idle();
        repeat (L - 2) step();
        chk("m0_a_val", get_out(0, 0), 100);
        chk("m0_a_nop", 64'(nop_a), 0);
        step();
        chk("m0_b_val", get_out(0, 0), 21000);
        chk("m0_b_nop", 64'(nop_a), 0);
        step();
        chk("m0_after_nop", 64'(nop_a), 1);
        chk("m0_after_hold", get_out(0, 0), 21000);

        // mode 1, four-beat accumulation
        for (int k = 0; k < 4; k++) begin
            w_l[0] = 3; i_l[0] = -16'sd2;
            set_beat(1'b1, k == 0, k == 3);
            step();
        end
        set_idle();
        repeat (L - 2) step();
        chk("m1_beat3_nop", 64'(nop_a), 1);
        chk("m1_beat3_hold", get_out(0, 0), 21000);
        step();
        chk("m1_sum", get_out(0, 0), -24);
        chk("m1_sum_nop", 64'(nop_a), 0);

        // stall mid-flight
        w_l[0] = 100; i_l[0] = 200; o_l[0] = 1000; set_beat(1'b0, 1'b0, 1'b0);
        step();
        set_idle();
        step();
        step();
        en = 1'b0;
        repeat (3) step();
        chk("stall_hold", get_out(0, 0), -24);
        en = 1'b1;
        step();
        chk("stall_pre_nop", 64'(nop_a), 1);
        step();
        chk("stall_val", get_out(0, 0), 21000);
        chk("stall_nop", 64'(nop_a), 0);

        // saturation boundaries on the 32-bit instances
        w_l[0] = 1;  i_l[0] = 1; o_l[0] = 40'sh007FFFFFFF;
        w_l[1] = -1; i_l[1] = 1; o_l[1] = 40'shFF80000000;
        set_beat(1'b0, 1'b0, 1'b0);
        step();
        set_idle();
        repeat (L - 1) step();
        chk("sat_pos", get_out(1, 0), 64'sd2147483647);
        chk("wrap_pos", get_out(2, 0), -64'sd2147483648);
        chk("wide_pos", get_out(0, 0), 64'sd2147483648);
        chk("sat_neg", get_out(1, 1), -64'sd2147483648);
        chk("wrap_neg", get_out(2, 1), 64'sd2147483647);

        // lane isolation
        w_l[0] = 7;           i_l[0] = -16'sd9;     o_l[0] = 5;
        w_l[1] = 16'sd32767;  i_l[1] = 16'sd32767;
        w_l[2] = -16'sd32768; i_l[2] = 16'sd32767;
        w_l[3] = -16'sd32768; i_l[3] = -16'sd32768;
        set_beat(1'b0, 1'b0, 1'b0);
        step();
        set_idle();
        repeat (L - 1) step();
        chk("iso_l0", get_out(0, 0), -58);
        chk("iso_l1", get_out(0, 1), 1073676289);
        chk("iso_l2", get_out(0, 2), -1073709056);
        chk("iso_l3", get_out(0, 3), 1073741824);

        // reset with beats in flight and a non-zero accumulator
        w_l[0] = 5; i_l[0] = 5; set_beat(1'b1, 1'b1, 1'b0);
        step();
        set_idle();
        repeat (L - 1) step();
        for (int k = 0; k < 3; k++) begin
            w_l[0] = 9; i_l[0] = 9; set_beat(1'b0, 1'b0, 1'b0);
            step();
        end
        set_idle();
        aclr = 1'b1;
        step();
        chk("rst_flight_nop", 64'(nop_a), 1);
        chk("rst_flight_dout", get_out(0, 0), 0);
        aclr = 1'b0;
        w_l[0] = 2; i_l[0] = 3; set_beat(1'b1, 1'b0, 1'b1);
        step();
        set_idle();
        repeat (L - 2) step();
        chk("rst_drain_nop", 64'(nop_a), 1);
        chk("rst_drain_dout", get_out(0, 0), 0);
        step();
        chk("rst_acc_zero", get_out(0, 0), 6);
        chk("rst_first_nop", 64'(nop_a), 0);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            aclr     = ($urandom_range(0, 199) == 0);
            en       = ($urandom_range(0, 9) != 0);
            nop_in   = ($urandom_range(0, 3) == 0);
            acc_mode = 1'($urandom_range(0, 1));
            first    = ($urandom_range(0, 2) == 0);
            last     = ($urandom_range(0, 2) == 0);
            for (int l = 0; l < LN; l++) begin
                w_l[l] = rand_op();
                i_l[l] = rand_op();
                r64    = {$urandom(), $urandom()};
                o_l[l] = r64[AW-1:0];
            end
            step();
        end

        aclr = 1'b0; en = 1'b1;
        set_idle();
        repeat (L + 2) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
